// File: rtl/mem_loader_pkg.sv
// Shared definitions for the memory stream loader.
//   word_size    : data/address width of the memory unit
//   memory_size  : number of addressable words (address arithmetic wraps at this)
//   cnt_width    : width of the remaining-word counter (must hold memory_size)
//   CMD_LOAD/DUMP: frame command bytes
//   state_t      : loader FSM states
//   is_cmd()     : true for a byte that starts a valid frame
package mem_loader_pkg;

    localparam int word_size   = 8;
    localparam int memory_size = 256;
    localparam int cnt_width   = $clog2(memory_size) + 1;

    localparam logic [word_size-1:0] CMD_LOAD = 8'hA5;
    localparam logic [word_size-1:0] CMD_DUMP = 8'h5A;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        CNT,
        W_DATA,
        W_STROBE,
        R_ISSUE,
        R_WAIT,
        CHK,
        FINISH
    } state_t;

    function automatic logic is_cmd(input logic [word_size-1:0] b);
        return (b == CMD_LOAD) || (b == CMD_DUMP);
    endfunction

endpackage

// File: rtl/mem_loader_ptr.sv
// Pointer / remaining-count register pair for the memory stream loader.
//   clk        : clock, rising edge
//   rst        : synchronous active-low reset
//   load_ptr   : load the pointer from load_value
//   load_cnt   : load the count from load_value (0 means memory_size words)
//   step       : advance pointer (wrapping) and decrement count
//   load_value : byte supplying pointer or count
//   ptr        : current memory pointer
//   last_step  : high on the step that empties the count
module mem_loader_ptr
    import mem_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_ptr,
    input  logic                 load_cnt,
    input  logic                 step,
    input  logic [word_size-1:0] load_value,
    output logic [word_size-1:0] ptr,
    output logic                 last_step
);

    localparam logic [word_size-1:0] PTR_MAX = word_size'(memory_size - 1);

    logic [word_size-1:0] ptr_reg;
    logic [cnt_width-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_reg <= '0;
            cnt_reg <= '0;
        end else begin
            if (load_ptr)
                ptr_reg <= load_value;
            else if (step)
                ptr_reg <= (ptr_reg == PTR_MAX) ? '0 : ptr_reg + 1'b1;

            // A zero count byte is the only way to request a full sweep.
            if (load_cnt)
                cnt_reg <= (load_value == '0) ? cnt_width'(memory_size)
                                              : cnt_width'(load_value);
            else if (step)
                cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign ptr       = ptr_reg;
    assign last_step = step && (cnt_reg == cnt_width'(1));

endmodule

// File: rtl/mem_stream_loader.sv
// Bus-master loader for the RISC-SPM single-port memory. Takes framed bytes
// from a host link and either writes them into memory (LOAD: cmd, addr, count,
// data...) or streams memory back out (DUMP: cmd, addr, count). cpu_hold keeps
// the processor off the bus for the duration of a frame.
// Optional build macro: MEM_LOADER_CHECKSUM_EN -- adds an 8-bit running sum
// over addr/count/data; LOAD takes a trailer byte that must zero the sum,
// DUMP appends the two's complement of the sum.
// Ports:
//   clk, rst (synchronous, active low)
//   in_data/in_valid/in_ready    : host -> loader byte stream
//   out_data/out_valid/out_ready : loader -> host dump stream
//   mem_address, mem_data_out, mem_write : memory bus (write on clk edge)
//   mem_data_in                  : combinational read data
//   cpu_hold : loader owns the bus; done : frame-complete pulse; err : sticky
module mem_stream_loader
    import mem_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [word_size-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [word_size-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [word_size-1:0] mem_address,
    output logic [word_size-1:0] mem_data_out,
    input  logic [word_size-1:0] mem_data_in,
    output logic                 mem_write,
    output logic                 cpu_hold,
    output logic                 done,
    output logic                 err
);

    state_t state_reg, state_next;
    logic   is_load_reg, is_load_next;
    logic [word_size-1:0] mem_data_out_reg, mem_data_out_next;
    logic [word_size-1:0] out_data_reg, out_data_next;
    logic   in_ready_reg, in_ready_next;
    logic   out_valid_reg, out_valid_next;
    logic   mem_write_reg, mem_write_next;
    logic   cpu_hold_reg, cpu_hold_next;
    logic   done_reg, done_next;
    logic   err_reg, err_next;

    logic   accept, out_fire;
    logic   load_ptr, load_cnt, step, last_step;
    logic [word_size-1:0] ptr;

`ifdef MEM_LOADER_CHECKSUM_EN
    logic [word_size-1:0] sum_reg, sum_next, chk_total;
`endif

    assign accept   = in_valid && in_ready_reg;
    assign out_fire = out_valid_reg && out_ready;

    mem_loader_ptr u_ptr (
        .clk        (clk),
        .rst        (rst),
        .load_ptr   (load_ptr),
        .load_cnt   (load_cnt),
        .step       (step),
        .load_value (in_data),
        .ptr        (ptr),
        .last_step  (last_step)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg        <= IDLE;
            is_load_reg      <= 1'b0;
            mem_data_out_reg <= '0;
            out_data_reg     <= '0;
            in_ready_reg     <= 1'b0;
            out_valid_reg    <= 1'b0;
            mem_write_reg    <= 1'b0;
            cpu_hold_reg     <= 1'b0;
            done_reg         <= 1'b0;
            err_reg          <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
            sum_reg          <= '0;
`endif
        end else begin
            state_reg        <= state_next;
            is_load_reg      <= is_load_next;
            mem_data_out_reg <= mem_data_out_next;
            out_data_reg     <= out_data_next;
            in_ready_reg     <= in_ready_next;
            out_valid_reg    <= out_valid_next;
            mem_write_reg    <= mem_write_next;
            cpu_hold_reg     <= cpu_hold_next;
            done_reg         <= done_next;
            err_reg          <= err_next;
`ifdef MEM_LOADER_CHECKSUM_EN
            sum_reg          <= sum_next;
`endif
        end
    end

    always_comb begin
        state_next        = state_reg;
        is_load_next      = is_load_reg;
        mem_data_out_next = mem_data_out_reg;
        out_data_next     = out_data_reg;
        err_next          = err_reg;
        load_ptr          = 1'b0;
        load_cnt          = 1'b0;
        step              = 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
        sum_next          = sum_reg;
        chk_total         = sum_reg + in_data;
`endif

        case (state_reg)
            IDLE: if (accept) begin
                if (is_cmd(in_data)) begin
                    state_next   = ADDR;
                    is_load_next = (in_data == CMD_LOAD);
                end else begin
                    err_next = 1'b1;
                end
            end
            ADDR: if (accept) begin
                load_ptr   = 1'b1;
                state_next = CNT;
`ifdef MEM_LOADER_CHECKSUM_EN
                sum_next   = in_data;
`endif
            end
            CNT: if (accept) begin
                load_cnt   = 1'b1;
                state_next = is_load_reg ? W_DATA : R_ISSUE;
`ifdef MEM_LOADER_CHECKSUM_EN
                sum_next   = sum_reg + in_data;
`endif
            end
            W_DATA: if (accept) begin
                mem_data_out_next = in_data;
                state_next        = W_STROBE;
`ifdef MEM_LOADER_CHECKSUM_EN
                sum_next          = sum_reg + in_data;
`endif
            end
            W_STROBE: begin
                step = 1'b1;
`ifdef MEM_LOADER_CHECKSUM_EN
                state_next = last_step ? CHK : W_DATA;
`else
                state_next = last_step ? FINISH : W_DATA;
`endif
            end
            R_ISSUE: begin
                // mem_address already shows the pointer; capture the read now.
                out_data_next = mem_data_in;
                state_next    = R_WAIT;
`ifdef MEM_LOADER_CHECKSUM_EN
                sum_next      = sum_reg + mem_data_in;
`endif
            end
            R_WAIT: if (out_fire) begin
                step = 1'b1;
                if (last_step) begin
`ifdef MEM_LOADER_CHECKSUM_EN
                    out_data_next = -sum_reg;
                    state_next    = CHK;
`else
                    state_next    = FINISH;
`endif
                end else begin
                    state_next = R_ISSUE;
                end
            end
            CHK: begin
`ifdef MEM_LOADER_CHECKSUM_EN
                if (is_load_reg) begin
                    if (accept) begin
                        if (chk_total != '0)
                            err_next = 1'b1;
                        state_next = FINISH;
                    end
                end else if (out_fire) begin
                    state_next = FINISH;
                end
`else
                state_next = FINISH;
`endif
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Control outputs are registered decodes of the next state, so they
        // are exact per-state values and read 0 while reset is held.
        in_ready_next  = (state_next inside {IDLE, ADDR, CNT, W_DATA})
                      || (state_next == CHK && is_load_next);
        out_valid_next = (state_next == R_WAIT)
                      || (state_next == CHK && !is_load_next);
        mem_write_next = (state_next == W_STROBE);
        cpu_hold_next  = !(state_next inside {IDLE, FINISH});
        done_next      = (state_next == FINISH);
    end

    assign in_ready     = in_ready_reg;
    assign out_valid    = out_valid_reg;
    assign out_data     = out_data_reg;
    assign mem_write    = mem_write_reg;
    assign mem_data_out = mem_data_out_reg;
    assign mem_address  = ptr;
    assign cpu_hold     = cpu_hold_reg;
    assign done         = done_reg;
    assign err          = err_reg;

endmodule

// File: tb/tb_mem_stream_loader.sv
// Directed bench for mem_stream_loader with a memory model and scoreboards
// for expected memory writes and expected dump bytes.
module tb_mem_stream_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] mem_address;
    logic [7:0] mem_data_out;
    logic [7:0] mem_data_in;
    logic       mem_write;
    logic       cpu_hold;
    logic       done;
    logic       err;

    always #5 clk = ~clk;

    mem_stream_loader dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .mem_address  (mem_address),
        .mem_data_out (mem_data_out),
        .mem_data_in  (mem_data_in),
        .mem_write    (mem_write),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err          (err)
    );

    // Memory unit model: combinational read, write on clock edge.
    logic [7:0] mem [0:255];
    assign mem_data_in = mem[mem_address];
    always @(posedge clk) if (mem_write === 1'b1) mem[mem_address] <= mem_data_out;

    int n_cmp = 0;
    int n_mis = 0;
    logic [15:0] exp_wr[$];
    logic [7:0]  exp_out[$];
    bit mon_en  = 0;
    bit prev_mw = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard side: compare every write strobe and every dump handshake.
    always @(negedge clk) if (mon_en) begin
        if (mem_write === 1'b1) begin
            logic [15:0] e;
            check("wr_pulse_single", 32'(prev_mw), 0);
            check("wr_cpu_hold", 32'(cpu_hold), 1);
            check("wr_expected", 32'(exp_wr.size() > 0), 1);
            if (exp_wr.size() > 0) begin
                e = exp_wr.pop_front();
                $display("write addr=%02h data=%02h", mem_address, mem_data_out);
                check("wr_addr_data", {16'h0, mem_address, mem_data_out}, {16'h0, e});
            end
        end
        prev_mw = (mem_write === 1'b1);
        if (out_valid === 1'b1) check("rdy_vld_excl", 32'(in_ready), 0);
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            check("out_expected", 32'(exp_out.size() > 0), 1);
            if (exp_out.size() > 0) begin
                $display("dump byte=%02h", out_data);
                check("out_data", 32'(out_data), 32'(exp_out.pop_front()));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic send(input logic [7:0] b);
        bit acc = 0;
        in_valid = 1'b1;
        in_data  = b;
        for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge clk);
            acc = (in_ready === 1'b1);
            @(posedge clk);
            #1;
        end
        check("send_accepted", 32'(acc), 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        check({tag, "_done_seen"}, 32'(seen), 1);
        if (seen) begin
            check({tag, "_hold_at_done"}, 32'(cpu_hold), 0);
            @(negedge clk);
            check({tag, "_done_one_cycle"}, 32'(done), 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input logic [7:0] a, input int n, input logic [7:0] d0,
                              input logic [7:0] dstep, input bit bad_trailer);
        logic [7:0] cntb, d, ai;
`ifdef MEM_LOADER_CHECKSUM_EN
        logic [7:0] sum;
`endif
        cntb = 8'(n);
        send(8'hA5);
        check("load_hold_after_cmd", 32'(cpu_hold), 1);
        send(a);
        send(cntb);
`ifdef MEM_LOADER_CHECKSUM_EN
        sum = a + cntb;
`endif
        for (int i = 0; i < n; i++) begin
            ai = a + 8'(i);
            d  = d0 + dstep * 8'(i);
            exp_wr.push_back({ai, d});
`ifdef MEM_LOADER_CHECKSUM_EN
            sum = sum + d;
`endif
            send(d);
        end
`ifdef MEM_LOADER_CHECKSUM_EN
        send(bad_trailer ? 8'h00 : 8'(-sum));
`else
        if (bad_trailer) $display("note: trailer not used in this build");
`endif
        wait_done("load");
        check("load_wr_drained", 32'(exp_wr.size()), 0);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit seen;
        rst       = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        out_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mon_en = 1;

        // Reset held with a command byte presented.
        repeat (3) begin
            @(negedge clk);
            check("rst_ctrl", {26'h0, in_ready, out_valid, mem_write, cpu_hold, done, err}, 0);
            check("rst_data", {8'h0, mem_address, mem_data_out, out_data}, 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;

        // Basic LOAD.
        load_frame(8'h10, 3, 8'h11, 8'h11, 0);
        check("mem_12", 32'(mem[8'h12]), 32'h33);

        // LOAD with address wrap.
        load_frame(8'hFE, 3, 8'hAA, 8'h11, 0);
        check("mem_00_wrap", 32'(mem[8'h00]), 32'hCC);

        // Count 0 -> full 256-word sweep from address 00.
        load_frame(8'h00, 256, 8'h5C, 8'h03, 0);
        check("mem_ff_full", 32'(mem[8'hFF]), 32'(8'(8'h5C + 8'h03 * 8'hFF)));

        // DUMP with backpressure.
        mem[8'h80] = 8'h03;
        mem[8'h81] = 8'h02;
        exp_out.push_back(8'h03);
        exp_out.push_back(8'h02);
`ifdef MEM_LOADER_CHECKSUM_EN
        exp_out.push_back(8'h79);
`endif
        send(8'h5A);
        send(8'h80);
        send(8'h02);
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = (out_valid === 1'b1);
        end
        check("dump_valid_seen", 32'(seen), 1);
        repeat (5) begin
            check("bp_valid", 32'(out_valid), 1);
            check("bp_data", 32'(out_data), 32'h03);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_done("dump");
        out_ready = 1'b0;
        check("dump_out_drained", 32'(exp_out.size()), 0);

        // Bad command, then a LOAD that still completes.
        check("err_before_bad", 32'(err), 0);
        send(8'h00);
        @(negedge clk);
        check("bad_err", 32'(err), 1);
        check("bad_hold", 32'(cpu_hold), 0);
        check("bad_idle_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        load_frame(8'h20, 1, 8'h77, 8'h00, 0);
        check("err_sticky", 32'(err), 1);
        check("mem_20", 32'(mem[8'h20]), 32'h77);

        // Reset mid-frame: no writes, bus released, err cleared.
        send(8'hA5);
        send(8'h40);
        do_reset(2);
        @(negedge clk);
        check("midrst_hold", 32'(cpu_hold), 0);
        check("midrst_err", 32'(err), 0);
        check("midrst_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;

`ifdef MEM_LOADER_CHECKSUM_EN
        mem[8'h80] = 8'h00;
        load_frame(8'h80, 1, 8'h05, 8'h00, 0);
        check("chk_good_err", 32'(err), 0);
        check("chk_good_mem", 32'(mem[8'h80]), 32'h05);
        mem[8'h80] = 8'h00;
        load_frame(8'h80, 1, 8'h05, 8'h00, 1);
        check("chk_bad_err", 32'(err), 1);
        check("chk_bad_mem", 32'(mem[8'h80]), 32'h05);
`else
        load_frame(8'h80, 1, 8'h05, 8'h00, 0);
        check("plain_err", 32'(err), 0);
        check("plain_mem", 32'(mem[8'h80]), 32'h05);
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/mem_stream_loader.md
Name: mem_stream_loader

Overview:
- Bus-master initiator for the RISC-SPM single-port memory unit.
  - The memory reads combinationally from its address.
  - It writes on the clock edge when its write strobe is high.
- Accepts a framed byte stream (valid/ready) from a host link.
- Executes LOAD (stream bytes into memory) or DUMP (stream memory bytes back out).
- Holds the processor off the memory bus while active, via cpu_hold.

Parameters:
- word_size, 8, data and address width in bits.
- memory_size, 256, number of addressable words; address arithmetic wraps modulo memory_size.
- CMD_LOAD, 8'hA5, command byte that starts a LOAD frame.
- CMD_DUMP, 8'h5A, command byte that starts a DUMP frame.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- in_data  input  word_size  host stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts in_data this cycle.
- out_data  output  word_size  dump byte to host.
- out_valid  output  1  out_data valid.
- out_ready  input  1  host accepts out_data.
- mem_address  output  word_size  address to memory unit.
- mem_data_out  output  word_size  write data to memory unit.
- mem_data_in  input  word_size  combinational read data from memory unit.
- mem_write  output  1  memory write strobe.
- cpu_hold  output  1  high while the loader owns the memory bus.
- done  output  1  one-cycle pulse at frame completion.
- err  output  1  sticky; set on bad command (and on bad checksum if CHECKSUM_EN); cleared only by reset.

Behaviour:
- Reset (rst==0 at a clk edge):
  - State goes to IDLE.
  - All outputs go to 0: mem_address, mem_data_out, out_data, in_ready, out_valid, mem_write, cpu_hold, done, err.
  - Reset mid-frame abandons the frame with no further writes.
- A byte is accepted on the cycle where in_valid && in_ready.
- States:
  - IDLE:
    - in_ready=1.
    - Accepted CMD_LOAD or CMD_DUMP goes to ADDR and sets cpu_hold=1.
    - Any other accepted byte sets err and stays in IDLE.
  - ADDR: in_ready=1; the accepted byte loads the pointer, then go to CNT.
  - CNT:
    - in_ready=1; the accepted byte loads the remaining count; count 0 means memory_size words.
    - Next state is W_DATA for LOAD, or R_ISSUE for DUMP.
  - W_DATA: in_ready=1; the accepted byte is registered into mem_data_out, then go to W_STROBE.
  - W_STROBE:
    - in_ready=0; mem_write=1 for exactly this cycle, with mem_address=pointer.
    - Pointer increments (wraps 8'hFF to 8'h00) and count decrements.
    - If the count reaches zero, go to FINISH; otherwise return to W_DATA.
    - LOAD throughput is 1 byte per 2 cycles maximum.
  - R_ISSUE: mem_address=pointer; out_data is registered from mem_data_in, out_valid is set, then go to R_WAIT.
  - R_WAIT:
    - out_valid and out_data are held stable until out_ready.
    - On handshake, out_valid drops, pointer increments with wrap, and count decrements.
    - If the count reaches zero, go to FINISH; otherwise go to R_ISSUE.
  - FINISH: done=1 for one cycle, cpu_hold=0, return to IDLE.
- Combinational ordering rules:
  - mem_write is never asserted outside W_STROBE.
  - in_ready and out_valid are never both 1.
- in_valid is ignored while in_ready=0. out_ready is ignored while out_valid=0.
- Count=0 LOAD writes all 256 locations starting at the pointer, wrapping through 8'hFF.

Optional Feature:
- Macro: MEM_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) covers the address, count and every data byte of a frame.
  - LOAD: after the last W_STROBE, state CHK accepts one trailer byte. If sum+trailer != 0, err is set. Then FINISH.
  - DUMP: after the last data byte, one extra out byte equal to the two's complement of the sum is sent with a normal handshake. Then FINISH.
- Undefined: no CHK state, no trailer byte; frames are exactly as above.

Decomposition:
- Shared package mem_loader_pkg holds:
  - the state enumeration (IDLE, ADDR, CNT, W_DATA, W_STROBE, R_ISSUE, R_WAIT, CHK, FINISH);
  - CMD_LOAD and CMD_DUMP;
  - word_size.
- One natural sub-module: mem_loader_ptr.
  - Pointer/count register pair with load, step and wrap.
  - Flags zero on the step that empties the count.
- Checksum logic is inline under the macro.

Test Plan:
- Reset: hold rst=0 for 3 cycles while in_valid=1 and in_data=8'hA5 -> all outputs 0, no mem_write.
- LOAD: stream A5,10,03,11,22,33 -> mem_write pulses at addresses 10,11,12 with data 11,22,33. Each pulse is 1 cycle, followed by a done pulse. cpu_hold is high from the A5 accept until FINISH.
- LOAD wrap: stream A5,FE,03,AA,BB,CC -> writes to FE,FF,00. Count 0 with address 00 -> 256 writes, ending at FF.
- DUMP with backpressure: memory 80=03, 81=02; stream 5A,80,02; hold out_ready=0 for 5 cycles -> out_data=03 stays stable with out_valid=1. Then 02 is sent, then done. No mem_write occurs.
- Bad command: send 8'h00 in IDLE -> err=1, state stays IDLE, cpu_hold=0. A following valid LOAD still completes with err still 1.
- Checksum (MEM_LOADER_CHECKSUM_EN): stream A5,80,01,05 with trailer 7A (sum 86) -> err=0. With trailer 00 -> err=1. The write at 80 occurs in both cases.
